// File: rtl/opll_bus_if.sv
// opll_bus_if: request handshake plus OPLL pin bundle for opll_bus_writer
//   i_valid/i_reg/i_data : write request from the host side
//   o_ready              : request buffer has room
//   o_D/o_A0/o_CS/o_WR   : OPLL CPU-bus pins, active high
//   o_busy/o_level       : activity flag and buffer occupancy
interface opll_bus_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic          i_valid;
    logic [7:0]    i_reg;
    logic [7:0]    i_data;
    logic          o_ready;
    logic [7:0]    o_D;
    logic          o_A0;
    logic          o_CS;
    logic          o_WR;
    logic          o_busy;
    logic [LW-1:0] o_level;

    modport master (
        output i_valid, i_reg, i_data,
        input  o_ready, o_D, o_A0, o_CS, o_WR, o_busy, o_level
    );

    modport slave (
        input  i_valid, i_reg, i_data,
        output o_ready, o_D, o_A0, o_CS, o_WR, o_busy, o_level
    );
endinterface

// File: rtl/opll_bus_writer.sv
// opll_bus_writer: buffers (register, data) requests and replays them as OPLL address/data bus writes
//   clk   : master clock (XIN rate)
//   rst_n : asynchronous active-low reset
//   bus   : opll_bus_if.slave -- request handshake in, OPLL pins / busy / level out
module opll_bus_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter int WR_CYCLES  = 4,
    parameter int ADDR_WAIT  = 12,
    parameter int DATA_WAIT  = 84
) (
    input  logic      clk,
    input  logic      rst_n,
    opll_bus_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {IDLE, A_SETUP, A_STROBE, A_WAIT, D_SETUP, D_STROBE, D_WAIT} state_t;

    state_t        state_q, state_d;
    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] count_q, count_d;
    logic          ready_q, busy_q;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    d_q, d_d;
    logic [7:0]    hold_q, hold_d;
    logic          a0_q, a0_d;
    // CS and WR are always equal, so one register drives both pins
    logic          strobe_q, strobe_d;
    logic          push, pop, done;

    assign push    = bus.i_valid && ready_q;
    assign done    = cnt_q == 8'd0;
    assign count_d = count_q + LW'(push) - LW'(pop);

    always_comb begin
        state_d  = state_q;
        cnt_d    = done ? cnt_q : cnt_q - 8'd1;
        d_d      = d_q;
        a0_d     = a0_q;
        strobe_d = strobe_q;
        hold_d   = hold_q;
        pop      = 1'b0;
        case (state_q)
            IDLE:     pop = count_q != '0;
            A_SETUP:  if (done) begin
                          state_d  = A_STROBE;
                          cnt_d    = 8'(WR_CYCLES - 1);
                          strobe_d = 1'b1;
                      end
            A_STROBE: if (done) begin
                          state_d  = A_WAIT;
                          cnt_d    = 8'(ADDR_WAIT - 1);
                          strobe_d = 1'b0;
                      end
            A_WAIT:   if (done) begin
                          state_d = D_SETUP;
                          cnt_d   = 8'd0;
                          d_d     = hold_q;
                          a0_d    = 1'b1;
                      end
            D_SETUP:  if (done) begin
                          state_d  = D_STROBE;
                          cnt_d    = 8'(WR_CYCLES - 1);
                          strobe_d = 1'b1;
                      end
            D_STROBE: if (done) begin
                          state_d  = D_WAIT;
                          cnt_d    = 8'(DATA_WAIT - 1);
                          strobe_d = 1'b0;
                      end
            D_WAIT:   if (done) begin
                          state_d = IDLE;
                          pop     = count_q != '0;
                      end
            default:  state_d = IDLE;
        endcase
        // Taking a new request (from IDLE, or straight off the end of D_WAIT) puts the address on the bus
        if (pop) begin
            state_d         = A_SETUP;
            cnt_d           = 8'd0;
            {d_d, hold_d}   = mem_q[rd_ptr_q];
            a0_d            = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            d_q      <= '0;
            hold_q   <= '0;
            a0_q     <= 1'b0;
            strobe_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            d_q      <= d_d;
            hold_q   <= hold_d;
            a0_q     <= a0_d;
            strobe_q <= strobe_d;
            wr_ptr_q <= wr_ptr_q + AW'(push);
            rd_ptr_q <= rd_ptr_q + AW'(pop);
            count_q  <= count_d;
            ready_q  <= count_d != LW'(FIFO_DEPTH);
            busy_q   <= (count_d != '0) || (state_d != IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {bus.i_reg, bus.i_data};
    end

    assign bus.o_ready = ready_q;
    assign bus.o_D     = d_q;
    assign bus.o_A0    = a0_q;
    assign bus.o_CS    = strobe_q;
    assign bus.o_WR    = strobe_q;
    assign bus.o_busy  = busy_q;
    assign bus.o_level = count_q;
endmodule

// File: tb/tb_opll_bus_writer.sv
// tb_opll_bus_writer: scoreboard bench for opll_bus_writer (default and corner parameter instances)
module tb_opll_bus_writer;
    localparam int W   = 4,  AWT = 12, DW  = 84,  P  = 2 + 2 * W + AWT + DW;
    localparam int W2  = 1,  AW2 = 1,  DW2 = 255, P2 = 2 + 2 * W2 + AW2 + DW2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   total = 0, bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    opll_bus_if #(.FIFO_DEPTH(4)) a ();
    opll_bus_if #(.FIFO_DEPTH(4)) b ();

    opll_bus_writer #(.FIFO_DEPTH(4), .WR_CYCLES(W), .ADDR_WAIT(AWT), .DATA_WAIT(DW))
        dut (.clk(clk), .rst_n(rst_n), .bus(a));
    opll_bus_writer #(.FIFO_DEPTH(4), .WR_CYCLES(W2), .ADDR_WAIT(AW2), .DATA_WAIT(DW2))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Expected bus words {A0, D}, two per accepted request, in issue order
    logic [8:0] exp_q[$];
    int         arise[$];
    logic [8:0] e, w_rise;
    logic       prev_wr = 1'b0;
    int         rise_t = 0, fall_t = -1;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_wr = 1'b0;
            fall_t  = -1;
        end else begin
            if (a.o_WR && !prev_wr) begin
                rise_t = cyc;
                w_rise = {a.o_A0, a.o_D};
                chk("cs_at_rise", 32'(a.o_CS), 1);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_write: got %h expected no write at cycle %0d", w_rise, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("bus_word", 32'(w_rise), 32'(e));
                end
                if (a.o_A0) chk("addr_gap", cyc - fall_t, AWT + 1);
                else begin
                    arise.push_back(cyc);
                    if (fall_t >= 0) chk("data_gap_min", 32'(cyc - fall_t >= DW + 1), 1);
                end
            end else if (!a.o_WR && prev_wr) begin
                chk("wr_width", cyc - rise_t, W);
                chk("cs_at_fall", 32'(a.o_CS), 0);
                chk("hold", 32'({a.o_A0, a.o_D}), 32'(w_rise));
                fall_t = cyc;
            end
            prev_wr = a.o_WR;
        end
    end

    int         rb[$], fb[$];
    logic [8:0] wb[$];
    logic       prev_wr2 = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) prev_wr2 = 1'b0;
        else begin
            if (b.o_WR && !prev_wr2) begin
                rb.push_back(cyc);
                wb.push_back({b.o_A0, b.o_D});
            end
            if (!b.o_WR && prev_wr2) fb.push_back(cyc);
            prev_wr2 = b.o_WR;
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge, with acc = that edge
    task automatic send(input logic [7:0] r, input logic [7:0] d, output int acc);
        int n = 0;
        a.i_valid = 1'b1;
        a.i_reg   = r;
        a.i_data  = d;
        while (!a.o_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        acc = cyc + 1;
        if (!a.o_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got o_ready=0 expected 1 within 2000 cycles");
        end else begin
            exp_q.push_back({1'b0, r});
            exp_q.push_back({1'b1, d});
        end
        @(negedge clk);
        a.i_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || a.o_busy) && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk(name, exp_q.size(), 0);
        chk({name, "_busy"}, 32'(a.o_busy), 0);
    endtask

    initial begin
        int n0, acc, acc0;
        logic [8:0] exp2 [4];
        a.i_valid = 1'b0; a.i_reg = '0; a.i_data = '0;
        b.i_valid = 1'b0; b.i_reg = '0; b.i_data = '0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(a.o_ready), 0);
        chk("rst_bus", 32'({a.o_D, a.o_A0, a.o_CS, a.o_WR}), 0);
        chk("rst_busy", 32'(a.o_busy), 0);
        chk("rst_level", 32'(a.o_level), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(a.o_ready), 1);

        // Single write with spec timing relative to the accepting edge N
        send(8'h10, 8'h55, n0);
        for (int t = n0; t <= n0 + 108; t++) begin
            if (t > n0) @(negedge clk);
            chk("single_wr", 32'(a.o_WR),
                32'((t >= n0 + 2 && t <= n0 + 5) || (t >= n0 + 19 && t <= n0 + 22)));
            chk("single_busy", 32'(a.o_busy), 32'(t < n0 + 107));
            if (t == n0 + 1)  chk("single_addr", 32'({a.o_A0, a.o_D}), 32'({1'b0, 8'h10}));
            if (t == n0 + 18) chk("single_data", 32'({a.o_A0, a.o_D}), 32'({1'b1, 8'h55}));
        end
        drain("single_drain");

        // Corner parameters on the second instance
        exp2[0] = {1'b0, 8'h21}; exp2[1] = {1'b1, 8'h3C};
        exp2[2] = {1'b0, 8'h22}; exp2[3] = {1'b1, 8'h4D};
        b.i_valid = 1'b1; b.i_reg = 8'h21; b.i_data = 8'h3C;
        chk("corner_ready", 32'(b.o_ready), 1);
        acc0 = cyc + 1;
        @(negedge clk);
        b.i_reg = 8'h22; b.i_data = 8'h4D;
        @(negedge clk);
        b.i_valid = 1'b0;
        for (int n = 0; n < 1000 && fb.size() < 4; n++) @(negedge clk);
        chk("corner_writes", fb.size(), 4);
        if (fb.size() >= 4) begin
            chk("corner_first_wr", rb[0], acc0 + 2);
            chk("corner_aw_width", fb[0] - rb[0], W2);
            chk("corner_addr_gap", rb[1] - fb[0], AW2 + 1);
            chk("corner_dw_width", fb[1] - rb[1], W2);
            chk("corner_period", rb[2] - rb[0], P2);
            for (int i = 0; i < 4; i++) chk("corner_word", 32'(wb[i]), 32'(exp2[i]));
        end

        // FIFO fill: one in service plus four queued, then the sixth waits for a pop
        arise.delete();
        for (int i = 0; i < 5; i++) begin
            send(8'($urandom), 8'($urandom), acc);
            if (i == 0) acc0 = acc;
        end
        chk("fill_b2b", acc - acc0, 4);
        chk("fill_ready_low", 32'(a.o_ready), 0);
        chk("fill_level", 32'(a.o_level), 4);
        send(8'($urandom), 8'($urandom), acc);
        chk("fill_accept_edge", acc - acc0, P + 2);
        drain("fill_drain");
        chk("fill_count", arise.size(), 6);
        for (int i = 1; i < arise.size(); i++) chk("fill_period", arise[i] - arise[i-1], P);

        // Push on the edge D_WAIT ends while one entry is queued
        send(8'hA1, 8'h11, n0);
        send(8'hA2, 8'h22, acc);
        while (cyc < n0 + P) @(negedge clk);
        send(8'hA3, 8'h33, acc);
        chk("sim_accept_edge", acc, n0 + P + 1);
        chk("sim_level", 32'(a.o_level), 1);
        drain("sim_drain");

        // Reset during the address strobe
        send(8'h33, 8'h44, n0);
        send(8'h35, 8'h46, acc);
        for (int n = 0; n < 50 && !a.o_WR; n++) @(negedge clk);
        chk("mid_strobe_seen", 32'(a.o_WR), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_wr_async", 32'(a.o_WR), 0);
        chk("rst_cs_async", 32'(a.o_CS), 0);
        chk("rst_level_async", 32'(a.o_level), 0);
        exp_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        send(8'h12, 8'h9A, n0);
        @(negedge clk);
        chk("post_rst_addr", 32'({a.o_A0, a.o_D, a.o_WR}), 32'({1'b0, 8'h12, 1'b0}));
        @(negedge clk);
        chk("post_rst_strobe", 32'(a.o_WR), 1);
        drain("post_rst_drain");

        // Random requests with random idle gaps
        for (int i = 0; i < 25; i++) begin
            send(8'($urandom), 8'($urandom), acc);
            repeat ($urandom_range(0, 150)) @(negedge clk);
        end
        drain("rand_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
